// File: rtl/mem_ctrl_pkg.sv
// Shared widths, the I/O-port address and the controller state type for mem_ctrl.
package mem_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] IO_ADDR = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response bus of mem_ctrl: the master drives requests, the slave answers.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              memrq;
  logic              rnw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;

  modport master (
    output memrq, rnw, addr, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  memrq, rnw, addr, wdata,
    output rdata, ready, busy
  );

endinterface

// File: rtl/mem_ram_4kx16.sv
// Single-port synchronous 4096x16 RAM with write enable and registered read; contents survive reset.
module mem_ram_4kx16
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Wait-state memory controller: captures a CPU request, waits WAIT_STATES cycles, accesses RAM, pulses ready.
// Optional build macro MEM_CTRL_IOPORT_EN maps address 12'hFFF to an 8-bit output port io_out.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
`ifdef MEM_CTRL_IOPORT_EN
  ,
  output logic [7:0] io_out
`endif
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  state_t            state;
  state_t            next_state;
  logic [2:0]        wait_cnt;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] read_word;
  logic [ADDR_W-1:0] ram_addr;
  logic              capture;
  logic              io_hit;
  logic              ram_we;
  logic              ram_re;

  assign capture = (state == IDLE) && bus.memrq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.memrq) next_state = (WAIT_STATES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt <= 3'd1) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are frozen at capture so bus activity mid-access is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 3'd0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (capture) begin
      wait_cnt <= WAIT_INIT;
      rnw_q    <= bus.rnw;
      addr_q   <= bus.addr;
      wdata_q  <= bus.wdata;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

`ifdef MEM_CTRL_IOPORT_EN
  logic [7:0] io_q;

  assign io_hit    = (addr_q == IO_ADDR);
  assign read_word = io_hit ? {{(DATA_W-8){1'b0}}, io_q} : ram_rdata;
  assign io_out    = io_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      io_q <= 8'h00;
    end else if ((state == ACCESS) && !rnw_q && io_hit) begin
      io_q <= wdata_q[7:0];
    end
  end
`else
  assign io_hit    = 1'b0;
  assign read_word = ram_rdata;
`endif

  // The RAM read is launched on the edge entering ACCESS so the word is ready to register at its end;
  // with no wait states that edge is the capture edge, hence the live bus address while IDLE.
  assign ram_addr = (state == IDLE) ? bus.addr : addr_q;
  assign ram_re   = (next_state == ACCESS);
  assign ram_we   = (state == ACCESS) && !rnw_q && !io_hit;

  mem_ram_4kx16 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state == ACCESS) && rnw_q) begin
      rdata_q <= read_word;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == DONE);
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a WAIT_STATES=2 instance for the main traffic and a WAIT_STATES=0 one
// for back-to-back requests; I/O-port checks are compiled in with MEM_CTRL_IOPORT_EN.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;

  mem_ctrl_if bus2();
  mem_ctrl_if bus0();

`ifdef MEM_CTRL_IOPORT_EN
  logic [7:0] io_out2;
  logic [7:0] io_out0;
  logic [7:0] io_model;
`endif

  mem_ctrl #(.WAIT_STATES(WS)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus2)
`ifdef MEM_CTRL_IOPORT_EN
    ,
    .io_out (io_out2)
`endif
  );

  mem_ctrl #(.WAIT_STATES(0)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus0)
`ifdef MEM_CTRL_IOPORT_EN
    ,
    .io_out (io_out0)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [0:4095];
  logic [15:0] last_rdata;
  logic [15:0] exp_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one request on the WAIT_STATES=2 instance; reads push their expected word, popped at ready.
  task automatic applyStimulus(input logic r, input logic [11:0] a, input logic [15:0] d,
                               input bit scramble);
    int          cyc;
    int          busy_cnt;
    bit          seen;
    logic [15:0] exp;
    @(negedge clk);
    checkOutput("idle_before", {31'd0, bus2.busy}, 32'd0);
    bus2.memrq = 1'b1;
    bus2.rnw   = r;
    bus2.addr  = a;
    bus2.wdata = d;
`ifdef MEM_CTRL_IOPORT_EN
    if (a == IO_ADDR) begin
      if (r) exp_q.push_back({8'h00, io_model});
      else   io_model = d[7:0];
    end else
`endif
    begin
      if (r) exp_q.push_back(model_mem[a]);
      else   model_mem[a] = d;
    end
    @(posedge clk);
    #1;
    bus2.memrq = 1'b0;
    if (scramble) begin
      bus2.addr  = 12'h000;
      bus2.wdata = ~d;
      bus2.rnw   = ~r;
    end
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus2.busy) busy_cnt++;
      if (bus2.ready) seen = 1'b1;
    end
    checkOutput("ready_latency", cyc, WS + 2);
    checkOutput("busy_cycles", busy_cnt, WS + 2);
    if (r) begin
      exp = exp_q.pop_front();
      checkOutput("rdata", {16'd0, bus2.rdata}, {16'd0, exp});
      last_rdata = exp;
    end else begin
      checkOutput("rdata_hold", {16'd0, bus2.rdata}, {16'd0, last_rdata});
    end
    @(negedge clk);
    checkOutput("ready_pulse", {31'd0, bus2.ready}, 32'd0);
    checkOutput("busy_end", {31'd0, bus2.busy}, 32'd0);
`ifdef MEM_CTRL_IOPORT_EN
    checkOutput("io_out", {24'd0, io_out2}, {24'd0, io_model});
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    logic [11:0] ra;
    logic [15:0] rd;

    rst = 1'b1;
    bus2.memrq = 1'b0; bus2.rnw = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    bus0.memrq = 1'b0; bus0.rnw = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    last_rdata = 16'h0000;
`ifdef MEM_CTRL_IOPORT_EN
    io_model = 8'h00;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, bus2.busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, bus2.ready}, 32'd0);
    checkOutput("rst_rdata", {16'd0, bus2.rdata}, 32'd0);
`ifdef MEM_CTRL_IOPORT_EN
    checkOutput("rst_io_out", {24'd0, io_out2}, 32'd0);
`endif
    rst = 1'b0;

    applyStimulus(1'b0, 12'h123, 16'hBEEF, 1'b0);
    applyStimulus(1'b1, 12'h123, 16'h0000, 1'b1);

    applyStimulus(1'b0, 12'h000, 16'h0001, 1'b0);
    applyStimulus(1'b0, 12'hFFE, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 12'hFFF, 16'h12A5, 1'b0);
    applyStimulus(1'b1, 12'h000, 16'h0000, 1'b0);
    applyStimulus(1'b1, 12'hFFE, 16'h0000, 1'b0);
    applyStimulus(1'b1, 12'hFFF, 16'h0000, 1'b0);
    applyStimulus(1'b1, 12'h123, 16'h0000, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = 12'($urandom_range(1, 4093));
      rd = 16'($urandom);
      applyStimulus(1'b0, ra, rd, 1'b0);
      applyStimulus(1'b1, ra, 16'h0000, 1'b0);
    end

    // Abort a write in WAIT with reset; the RAM must keep the earlier word.
    applyStimulus(1'b0, 12'h010, 16'h1111, 1'b0);
    @(negedge clk);
    bus2.memrq = 1'b1; bus2.rnw = 1'b0; bus2.addr = 12'h010; bus2.wdata = 16'h5555;
    @(posedge clk);
    #1;
    bus2.memrq = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_wait", {31'd0, bus2.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, bus2.busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, bus2.ready}, 32'd0);
    checkOutput("abort_rdata", {16'd0, bus2.rdata}, 32'd0);
    rst = 1'b0;
    last_rdata = 16'h0000;
`ifdef MEM_CTRL_IOPORT_EN
    io_model = 8'h00;
    checkOutput("abort_io_out", {24'd0, io_out2}, 32'd0);
`endif
    applyStimulus(1'b1, 12'h010, 16'h0000, 1'b0);

    // Zero-wait instance: write, then a read held high so it repeats right after returning to IDLE.
    @(negedge clk);
    bus0.memrq = 1'b1; bus0.rnw = 1'b0; bus0.addr = 12'h200; bus0.wdata = 16'hA0A0;
    @(posedge clk);
    #1;
    bus0.memrq = 1'b0;
    cyc = 0;
    while (!bus0.ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ws0_wr_latency", cyc, 32'd2);
    checkOutput("ws0_wr_rdata_hold", {16'd0, bus0.rdata}, 32'd0);
    @(negedge clk);
    bus0.memrq = 1'b1; bus0.rnw = 1'b1; bus0.addr = 12'h200;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus0.ready && cyc < 10);
    checkOutput("ws0_rd_latency", cyc, 32'd2);
    checkOutput("ws0_rd_rdata", {16'd0, bus0.rdata}, 32'h0000A0A0);
    @(negedge clk);
    checkOutput("ws0_idle_gap", {31'd0, bus0.busy}, 32'd0);
    @(negedge clk);
    checkOutput("ws0_rearm", {31'd0, bus0.busy}, 32'd1);
    bus0.memrq = 1'b0;
    @(negedge clk);
    checkOutput("ws0_rearm_ready", {31'd0, bus0.ready}, 32'd1);
    checkOutput("ws0_rearm_rdata", {16'd0, bus0.rdata}, 32'h0000A0A0);
    @(negedge clk);
    checkOutput("ws0_end_busy", {31'd0, bus0.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning the number of extra wait cycles inserted before each RAM access (legal range 0..7).
REQ-002 SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port memrq  input  1  CPU memory request.
REQ-005 SHALL have port rnw  input  1  access type: 1 = read, 0 = write.
REQ-006 SHALL have port addr  input  12  word address.
REQ-007 SHALL have port wdata  input  16  write data.
REQ-008 SHALL have port rdata  output  16  read data, registered.
REQ-009 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port io_out  output  8  output port register; present only with MEM_CTRL_IOPORT_EN.

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT, ACCESS and DONE.
REQ-013 In IDLE with memrq=1, SHALL capture addr, wdata and rnw into internal registers on the same edge, then go to WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0).
REQ-014 In IDLE, while memrq=0, SHALL remain in IDLE.
REQ-015 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 3-bit down-counter loaded at capture, then go to ACCESS.
REQ-016 ACCESS SHALL last 1 cycle, performing the RAM write (rnw=0) or RAM read (rnw=1) at the captured address.
REQ-017 DONE SHALL last 1 cycle with ready=1; rdata SHALL hold the read word during DONE.
REQ-018 DONE SHALL always go to IDLE.
REQ-019 Latency: ready SHALL be high exactly WAIT_STATES+2 cycles after the capturing edge.
REQ-020 memrq, addr, wdata and rnw SHALL be ignored outside IDLE; input changes mid-access SHALL NOT affect the captured access.
REQ-021 If memrq is still high when returning to IDLE, SHALL start a new access; the CPU drops memrq on ready to avoid a repeat.
REQ-022 rdata SHALL change only on read completion; after a write, rdata SHALL keep its previous value.
REQ-023 A read following a write to the same address SHALL return the new data.
REQ-024 Addresses SHALL be used unmodified over the full 0x000..0xFFF range, with no wrap or aliasing.

Reset
REQ-025 While rst=1 at a clock edge, SHALL force state=IDLE, counter=0, rdata=16'h0000, ready=0, busy=0 and io_out=8'h00.
REQ-026 Reset mid-operation SHALL abort the access; a write aborted before ACCESS SHALL NOT modify RAM.
REQ-027 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_CTRL_IOPORT_EN defined: a write to 12'hFFF SHALL load io_out with wdata[7:0] and SHALL NOT write RAM.
REQ-029 Macro MEM_CTRL_IOPORT_EN defined: a read of 12'hFFF SHALL return {8'h00, io_out}.
REQ-030 Macro MEM_CTRL_IOPORT_EN undefined: io_out port SHALL be absent, and 12'hFFF SHALL be ordinary RAM.

Structure
REQ-031 Package mem_ctrl_pkg SHALL hold ADDR_W=12, DATA_W=16, IO_ADDR=12'hFFF and the FSM state typedef.
REQ-032 RAM SHALL be a sub-module mem_ram_4kx16: single-port, synchronous, 4096x16, with write enable and registered read.

Verification
REQ-033 WAIT_STATES=2: write 0x123 <- 16'hBEEF -> ready pulses 4 cycles after capture; busy high for 4 cycles.
REQ-034 Read 0x123 after REQ-033 -> rdata=16'hBEEF with ready; change addr to 0x000 mid-WAIT -> rdata still 16'hBEEF.
REQ-035 WAIT_STATES=0: read -> ready 2 cycles after capture; memrq held high -> second access starts immediately after return to IDLE.
REQ-036 rst=1 during WAIT of write 0x010 <- 16'h5555 -> state IDLE, ready=0, rdata=0; a later read of 0x010 returns the prior value.
REQ-037 MEM_CTRL_IOPORT_EN: write 0xFFF <- 16'h12A5 -> io_out=8'hA5; read 0xFFF -> rdata=16'h00A5.
REQ-038 Boundary addresses: write/read 0x000 <- 16'h0001 and 0xFFE <- 16'hFFFF -> exact readback, with no aliasing.
